// File: rtl/avg_sched_pkg.sv
// Shared types and helpers for the round-robin averaging scheduler.
package avg_sched_pkg;

  localparam int NCH_DEF = 4;
  localparam int DW_DEF  = 16;
  localparam int MAX_NCH = 8;
  localparam int IDXW    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WB   = 2'd2
  } state_e;

  // First pending channel strictly after 'last', wrapping over 'nch' channels.
  // Returns 0 when nothing is pending; callers qualify with their own any-flag.
  function automatic logic [IDXW-1:0] rr_next_grant(input logic [MAX_NCH-1:0] pend,
                                                    input int nch,
                                                    input int last);
    int   idx;
    logic found;
    found         = 1'b0;
    rr_next_grant = '0;
    for (int k = 1; k <= MAX_NCH; k++) begin
      if (!found && (k <= nch)) begin
        idx = (last + k) % nch;
        if (pend[idx[IDXW-1:0]]) begin
          found         = 1'b1;
          rr_next_grant = idx[IDXW-1:0];
        end
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: pending vector plus last-served pointer in,
// one-hot grant and binary index out.
module rr_arbiter
  import avg_sched_pkg::*;
#(
  parameter  int NCH = NCH_DEF,
  localparam int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] pend_i,
  input  logic [IW-1:0]  last_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IW-1:0]  idx_o,
  output logic           any_o
);

  logic [MAX_NCH-1:0] pend_w;
  logic [IDXW-1:0]    sel_w;

  // Pick the next pending channel after the last one served and decode it.
  always_comb begin
    pend_w            = '0;
    pend_w[NCH-1:0]   = pend_i;
    sel_w             = rr_next_grant(pend_w, NCH, int'(last_i));
    idx_o             = sel_w[IW-1:0];
    any_o             = |pend_i;
    gnt_o             = '0;
    for (int i = 0; i < NCH; i++) begin
      gnt_o[i] = any_o && (idx_o == IW'(i));
    end
  end

endmodule

// File: rtl/avg_rr_sched.sv
// Round-robin scheduler sharing one add/halve datapath across NCH channels,
// keeping a running average per channel (first sample seeds the average).
module avg_rr_sched
  import avg_sched_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [NCH-1:0]    data_en,
  input  logic [NCH-1:0]    clr,
  output logic [NCH*DW-1:0] avg_data,
  output logic [NCH-1:0]    avg_valid,
  output logic [NCH-1:0]    overrun,
  output logic              busy
);

  localparam int IW = $clog2(NCH);

  // (a + b) / 2 with a DW+1 bit sum so it never overflows; LSB is truncated (floor).
  function automatic logic [DW-1:0] avg_halve(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW:1];
  endfunction

  logic [NCH-1:0] en_r0_q, en_r1_q, en_r2_q;
  logic [NCH-1:0] rise;
  logic [DW-1:0]  sbuf_q [NCH];
  logic [NCH-1:0] pend_q;
  logic [NCH-1:0] ovr_q;
  logic [NCH-1:0] pend_eff;
  logic [NCH-1:0] gnt;
  logic [IW-1:0]  gidx;
  logic           gany;
  logic           grant_fire;
  logic [NCH-1:0] gnt_fire;

  state_e         state_q;
  logic [IW-1:0]  last_q;
  logic [IW-1:0]  gidx_q;
  logic [DW-1:0]  op_q;
  logic [DW-1:0]  res_q;
  logic           kill_q;
  logic [DW-1:0]  avg_q [NCH];
  logic [NCH-1:0] seeded_q;
  logic [NCH-1:0] vld_q;
  logic           busy_q;

  assign rise = en_r1_q & ~en_r2_q;

  // A channel being cleared this cycle must not be granted, or its old sample
  // would slip through after the clear.
  assign pend_eff   = pend_q & ~clr;
  assign grant_fire = (state_q == IDLE) && gany;
  assign gnt_fire   = gnt & {NCH{grant_fire}};

  rr_arbiter #(.NCH(NCH)) u_arb (
    .pend_i (pend_eff),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gidx),
    .any_o  (gany)
  );

  // Three-flop enable chain; cleared on reset so a held enable re-announces itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_r0_q <= '0;
      en_r1_q <= '0;
      en_r2_q <= '0;
    end else begin
      en_r0_q <= data_en;
      en_r1_q <= en_r0_q;
      en_r2_q <= en_r1_q;
    end
  end

  // Pending and sticky overrun flags; clear wins over a new rise, a rise wins over a grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          pend_q[i] <= 1'b0;
          ovr_q[i]  <= 1'b0;
        end else if (rise[i]) begin
          pend_q[i] <= 1'b1;
          if (pend_q[i] && !gnt_fire[i]) ovr_q[i] <= 1'b1;
        end else if (gnt_fire[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  // One-deep sample buffer per channel, overwritten by every accepted rise.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rise[i] && !clr[i]) sbuf_q[i] <= data_in[i*DW +: DW];
    end
  end

  // Grant / compute / writeback sequencer plus per-channel averages.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= IW'(NCH - 1);
      gidx_q   <= '0;
      op_q     <= '0;
      res_q    <= '0;
      kill_q   <= 1'b0;
      seeded_q <= '0;
      vld_q    <= '0;
      busy_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) avg_q[i] <= '0;
    end else begin
      vld_q <= '0;
      case (state_q)
        IDLE: begin
          if (gany) begin
            gidx_q  <= gidx;
            last_q  <= gidx;
            op_q    <= sbuf_q[gidx];
            kill_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          res_q <= seeded_q[gidx_q] ? avg_halve(avg_q[gidx_q], op_q) : op_q;
          if (clr[gidx_q]) kill_q <= 1'b1;
          state_q <= WB;
        end
        WB: begin
          if (!kill_q && !clr[gidx_q]) begin
            avg_q[gidx_q]    <= res_q;
            seeded_q[gidx_q] <= 1'b1;
            vld_q[gidx_q]    <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          avg_q[i]    <= '0;
          seeded_q[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign avg_data[g*DW +: DW] = avg_q[g];
  end

  assign avg_valid = vld_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_avg_rr_sched.sv
// Directed bench for avg_rr_sched with hand-computed expected averages and latencies.
module tb_avg_rr_sched;

  localparam int NCH = 4;
  localparam int DW  = 16;

  logic              clk;
  logic              rst;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    data_en;
  logic [NCH-1:0]    clr;
  logic [NCH*DW-1:0] avg_data;
  logic [NCH-1:0]    avg_valid;
  logic [NCH-1:0]    overrun;
  logic              busy;

  int n_vec;
  int n_err;
  int ecnt;
  int vcount [NCH];
  int vfirst [NCH];

  avg_rr_sched #(.NCH(NCH), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_en   (data_en),
    .clr       (clr),
    .avg_data  (avg_data),
    .avg_valid (avg_valid),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, sample 1ns after the edge and log valid pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    for (int c = 0; c < NCH; c++) begin
      if (avg_valid[c]) begin
        vcount[c]++;
        if (vfirst[c] < 0) vfirst[c] = ecnt;
      end
    end
  endtask

  // Next tick becomes edge E0.
  task automatic arm();
    ecnt = -1;
    for (int c = 0; c < NCH; c++) begin
      vcount[c] = 0;
      vfirst[c] = -1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_clr(input int ch);
    clr[ch] = 1'b1;
    tick();
    clr[ch] = 1'b0;
  endtask

  task automatic do_sample(input int ch, input logic [15:0] val);
    arm();
    data_in[ch*DW +: DW] = val;
    data_en[ch] = 1'b1;
    for (int n = 0; n < 20 && vfirst[ch] < 0; n++) tick();
    data_en[ch] = 1'b0;
    tick();
    tick();
    tick();
  endtask

  function automatic logic [15:0] avg_of(input int ch);
    logic [NCH*DW-1:0] v;
    v = avg_data;
    return v[ch*DW +: DW];
  endfunction

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b0;
    data_in = '0;
    data_en = '0;
    clr     = '0;
    arm();
    tick();
    tick();
    tick();
    check_vec("rst_avg_data", 64'(avg_data), 64'h0);
    check_vec("rst_avg_valid", 64'(avg_valid), 64'h0);
    check_vec("rst_overrun", 64'(overrun), 64'h0);
    check_vec("rst_busy", 64'(busy), 64'h0);
    rst = 1'b1;
    tick();

    // Single channel: seed then average
    do_sample(0, 16'h1000);
    check_vec("ch0_seed_lat", 64'(vfirst[0]), 64'd5);
    check_vec("ch0_seed_avg", 64'(avg_of(0)), 64'h1000);
    check_vec("ch0_seed_pulses", 64'(vcount[0]), 64'd1);
    do_sample(0, 16'h3000);
    check_vec("ch0_avg_lat", 64'(vfirst[0]), 64'd5);
    check_vec("ch0_avg", 64'(avg_of(0)), 64'h2000);
    check_vec("ch0_avg_pulses", 64'(vcount[0]), 64'd1);

    // Truncation and no-overflow
    pulse_clr(0);
    check_vec("clr0_avg", 64'(avg_of(0)), 64'h0);
    do_sample(0, 16'h0003);
    do_sample(0, 16'h0000);
    check_vec("trunc_3_0", 64'(avg_of(0)), 64'h0001);
    pulse_clr(0);
    do_sample(0, 16'hFFFF);
    check_vec("seed_ffff", 64'(avg_of(0)), 64'hFFFF);
    do_sample(0, 16'hFFFF);
    check_vec("ffff_ffff", 64'(avg_of(0)), 64'hFFFF);

    // All four together after reset: channel order 0..3, 3 cycles apart
    do_reset();
    arm();
    data_in = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    data_en = 4'hF;
    for (int n = 0; n < 20; n++) tick();
    for (int c = 0; c < NCH; c++) begin
      check_vec($sformatf("all_lat%0d", c), 64'(vfirst[c]), 64'(5 + 3 * c));
      check_vec($sformatf("all_avg%0d", c), 64'(avg_of(c)), 64'(16 * (c + 1)));
      check_vec($sformatf("all_cnt%0d", c), 64'(vcount[c]), 64'd1);
    end
    data_en = '0;
    tick();
    tick();
    tick();

    // Overrun on channel 2 while others are queued
    do_reset();
    arm();
    data_in = {16'h0004, 16'h0044, 16'h0002, 16'h0001};
    data_en = 4'hF;
    tick();
    data_en[2] = 1'b0;
    tick();
    tick();
    data_in[2*DW +: DW] = 16'h0055;
    data_en[2] = 1'b1;
    while (ecnt < 20) tick();
    check_vec("ovr_flag", 64'(overrun), 64'h4);
    check_vec("ovr_avg2", 64'(avg_of(2)), 64'h0055);
    check_vec("ovr_cnt2", 64'(vcount[2]), 64'd1);
    check_vec("ovr_lat2", 64'(vfirst[2]), 64'd11);
    check_vec("ovr_lat3", 64'(vfirst[3]), 64'd14);
    data_en = '0;
    tick();
    tick();
    tick();
    check_vec("ovr_sticky", 64'(overrun), 64'h4);
    pulse_clr(2);
    check_vec("ovr_cleared", 64'(overrun), 64'h0);

    // clr during channel 1 CALC suppresses the writeback
    pulse_clr(1);
    do_sample(1, 16'h0400);
    check_vec("ch1_seed", 64'(avg_of(1)), 64'h0400);
    arm();
    data_in[1*DW +: DW] = 16'h0200;
    data_en[1] = 1'b1;
    tick();
    tick();
    tick();
    check_vec("busy_pre_grant", 64'(busy), 64'h0);
    tick();
    check_vec("busy_calc", 64'(busy), 64'h1);
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    while (ecnt < 12) tick();
    check_vec("kill_no_valid", 64'(vcount[1]), 64'd0);
    check_vec("kill_avg1", 64'(avg_of(1)), 64'h0);
    check_vec("kill_busy_idle", 64'(busy), 64'h0);
    data_en[1] = 1'b0;
    tick();
    tick();
    tick();
    do_sample(1, 16'h0800);
    check_vec("reseed_avg1", 64'(avg_of(1)), 64'h0800);
    check_vec("reseed_lat1", 64'(vfirst[1]), 64'd5);

    // Reset mid-CALC with enable held high
    arm();
    data_in[0*DW +: DW] = 16'h1234;
    data_en[0] = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    check_vec("pre_rst_busy", 64'(busy), 64'h1);
    rst = 1'b0;
    tick();
    check_vec("mid_rst_avg_data", 64'(avg_data), 64'h0);
    check_vec("mid_rst_valid", 64'(avg_valid), 64'h0);
    check_vec("mid_rst_overrun", 64'(overrun), 64'h0);
    check_vec("mid_rst_busy", 64'(busy), 64'h0);
    rst = 1'b1;
    arm();
    for (int n = 0; n < 20 && vfirst[0] < 0; n++) tick();
    check_vec("post_rst_lat", 64'(vfirst[0]), 64'd5);
    check_vec("post_rst_avg", 64'(avg_of(0)), 64'h1234);
    data_en = '0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avg_rr_sched.md
# avg_rr_sched

Round-robin scheduler that shares one averaging datapath among the vibration-detect sensor channels. Each channel presents a 16-bit sample with a level enable. The block edge-detects each enable, buffers one pending sample per channel, and grants the single add/halve unit to one channel at a time. It holds a running average per channel (first sample seeds, later samples give (avg+sample)/2) and replaces four replicated averagers in the vibrate_dect path.

## Interface
Parameters:
- NCH, 4, number of channels (2..8)
- DW, 16, sample/average width

Ports:
- clk  in  1  single system clock
- rst  in  1  reset; synchronous and active-low
- data_in  in  NCH*DW  channel samples, channel i at [i*DW +: DW]
- data_en  in  NCH  per-channel level enable; a rising edge announces a new sample
- clr  in  NCH  per-channel clear pulse (restart averaging)
- avg_data  out  NCH*DW  per-channel running average
- avg_valid  out  NCH  one-cycle pulse when avg_data of that channel updates
- overrun  out  NCH  sticky: sample overwritten before it was serviced
- busy  out  1  datapath not in IDLE

## Operation
- Edge detect per channel uses a 3-flop chain en_r0/en_r1/en_r2. rise = en_r1 & ~en_r2.
- On rise: capture data_in[i] into buf[i] and set pend[i]. If pend[i] is already set and not being granted this cycle, overwrite buf[i] and set overrun[i].
- FSM states and transitions:
  - IDLE: if any pend, grant channel g = first pending after last (wrapping). Copy buf[g] to op, clear pend[g], set last=g, go to CALC. Otherwise stay in IDLE.
  - CALC: if seeded[g]=0, res=op. Otherwise res = ({1'b0,avg[g]} + {1'b0,op}) >> 1, a DW+1 bit sum with the LSB truncated (floor, no overflow). Go to WB.
  - WB: write avg[g]=res, set seeded[g], pulse avg_valid[g]. Go to IDLE.
- A rise on channel g in the same cycle it is granted sets pend[g] again with the new buf. No overrun is flagged, because op already holds the old sample.
- clr[i] clears pend[i], seeded[i], overrun[i] and avg[i] to 0. clr beats a simultaneous rise on i, which is dropped.
- If clr[i] arrives while channel i is in CALC or WB, the writeback is suppressed: no avg_valid, avg stays 0, seeded stays 0. The FSM still returns to IDLE.
- Reset (rst=0 at a clk edge):
  - state IDLE, last=NCH-1 (channel 0 wins first).
  - pend, seeded, overrun, avg_data, avg_valid, op, res all 0.
  - en_r0..en_r2 = 0, so an enable already high at reset release produces a rise.
- Reset mid-operation abandons the in-flight sample with no pulse.

## Timing
- Count edge E0 as the first clk edge that samples data_en[i]=1.
- buf captured at E2, grant at E3, res at E4. avg_data updates and avg_valid goes high after E5, for exactly one cycle. No contention assumed.
- Service cost is 3 cycles per sample. With N channels pending, the worst-case wait is 3*(N-1) extra cycles.
- data_in[i] must be stable from E0 through E2. data_en must be low for at least 2 cycles between samples to give a new rise.
- busy is high in CALC and WB, and in the cycle after a grant.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package avg_sched_pkg holds:
  - state enum {IDLE, CALC, WB}
  - DW/NCH defaults
  - a round-robin next-grant function
- One natural sub-module: rr_arbiter (NCH-wide pending vector plus last pointer in, one-hot grant plus index out), combinational.
- Edge detect, buffers and the FSM live in the top.

## Test plan
- Single channel 0: data 0x1000 then 0x3000 (separate enable pulses).
  - avg 0x1000, then 0x2000.
  - Each avg_valid[0] pulse 5 cycles after enable rise.
- Truncation: avg 0x0003 plus sample 0x0000 gives 0x0001. 0xFFFF + 0xFFFF gives 0xFFFF (no overflow).
- All 4 enables rise together with 0x10, 0x20, 0x30, 0x40.
  - avg_valid pulses in channel order 0,1,2,3, 3 cycles apart.
  - Each avg equals its sample (seed).
- Overrun: channel 2 rises twice while channels 0, 1 and 3 are pending and busy. Second sample 0x55 is the one averaged, and overrun[2]=1 until clr[2].
- clr[1] asserted in channel 1's CALC cycle: no avg_valid[1], avg_data[1]=0. The next sample 0x0800 seeds to 0x0800.
- rst low while in CALC with data_en held high: all outputs 0. After release, the held enable produces a rise and a new seed.
